// File: rtl/bg_tile_fetcher_pkg.sv
// Shared definitions for the background tile fetcher: FSM states, nametable/attribute
// offsets, mirroring codes, the queued tile record and address helpers.
package bg_tile_fetcher_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_NT    = 3'd1,
        ST_AT    = 3'd2,
        ST_PLO   = 3'd3,
        ST_PHI   = 3'd4,
        ST_PUSH  = 3'd5,
        ST_DRAIN = 3'd6
    } fetch_state_t;

    localparam logic [15:0] NT_STRIDE    = 16'h0400;
    localparam logic [15:0] ATTR_OFF     = 16'h03C0;
    localparam logic [15:0] PT_PLANE_OFF = 16'h0008;

    localparam logic [1:0] MIR_VERT      = 2'd0;
    localparam logic [1:0] MIR_HORIZ     = 2'd1;
    localparam logic [1:0] MIR_SINGLE_LO = 2'd2;
    localparam logic [1:0] MIR_SINGLE_HI = 2'd3;

    typedef struct packed {
        logic [7:0] pat_lo;
        logic [7:0] pat_hi;
        logic [1:0] pal;
        logic [2:0] fine_x;
    } tile_t;

    function automatic logic [15:0] nt_addr(input logic [15:0] base, input logic [1:0] sel,
                                            input logic [4:0] tr, input logic [4:0] tc);
        return base + (NT_STRIDE * {14'd0, sel}) + {6'd0, tr, 5'd0} + {11'd0, tc};
    endfunction

    // One attribute byte covers a 4x4 tile block, so only the upper 3 bits of tr/tc select it.
    function automatic logic [15:0] at_addr(input logic [15:0] base, input logic [1:0] sel,
                                            input logic [4:0] tr, input logic [4:0] tc);
        return base + (NT_STRIDE * {14'd0, sel}) + ATTR_OFF + {10'd0, tr[4:2], 3'd0}
               + {13'd0, tc[4:2]};
    endfunction

    function automatic logic [1:0] mirror_sel(input logic [1:0] mode, input logic [1:0] sel);
        logic [1:0] res;
        case (mode)
            MIR_VERT:      res = {1'b0, sel[0]};
            MIR_HORIZ:     res = {1'b0, sel[1]};
            MIR_SINGLE_LO: res = 2'b00;
            default:       res = 2'b01;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/bg_tile_fetcher_fifo.sv
// Lookahead queue of finished tiles between the fetch FSM and the pixel shifter.
// Power-of-two depth, valid/ready pop, synchronous flush, occupancy count.
module bg_tile_fetcher_fifo
    import bg_tile_fetcher_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  tile_t         din,
    input  logic          pop,
    output tile_t         dout,
    output logic          valid,
    output logic [AW:0]   count
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    tile_t          mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           pop_fire;
    logic           push_fire;

    assign valid     = (count != '0);
    assign pop_fire  = pop & valid;
    // A pop in the same cycle frees the slot, so push at full is still accepted.
    assign push_fire = push & ((count < DEPTH_C) | pop_fire);
    assign dout      = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push_fire) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_fire) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_fire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_fire, pop_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bg_tile_fetcher.sv
// Background tile fetcher: scroll-adjusted screen coords -> NT/AT/pattern fetches over a
// req/ack VRAM port, finished tiles queued for the shifter. Define MIRROR_REMAP_EN to remap NT/AT bits [11:10].
module bg_tile_fetcher
    import bg_tile_fetcher_pkg::*;
#(
    parameter int          FIFO_DEPTH = 2,
    parameter logic [15:0] NT_BASE    = 16'h2000,
    parameter logic [15:0] PT_HI_BASE = 16'h1000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [8:0]                    req_row,
    input  logic [8:0]                    req_col,
    input  logic [15:0]                   scroll,
    input  logic [7:0]                    ppu_ctrl1,
    input  logic [1:0]                    mirror_mode,
    output logic                          mem_req,
    output logic [15:0]                   mem_addr,
    input  logic                          mem_ack,
    input  logic [7:0]                    mem_rdata,
    output logic                          tile_valid,
    input  logic                          tile_ready,
    output logic [7:0]                    tile_pat_lo,
    output logic [7:0]                    tile_pat_hi,
    output logic [1:0]                    tile_pal,
    output logic [2:0]                    tile_fine_x,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int          CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    fetch_state_t state;
    logic [1:0]   sel_reg;
    logic [4:0]   tr_reg;
    logic [4:0]   tc_reg;
    logic [2:0]   fy_reg;
    logic [2:0]   fine_x_reg;
    logic         pt_hi_reg;
    logic [7:0]   idx_reg;
    logic [1:0]   pal_reg;
    logic [7:0]   lo_reg;
    logic [7:0]   hi_reg;

    logic [10:0]  row_sum;
    logic [8:0]   row_wrap;
    logic [8:0]   col_wrap;
    logic [7:0]   r_local;
    logic [1:0]   raw_sel;
    logic [1:0]   eff_sel;
    logic [2:0]   attr_shift;
    logic [7:0]   attr_shifted;
    logic         fifo_push;
    tile_t        fifo_din;
    tile_t        fifo_dout;

    // Scrolled coordinates for the request currently on the inputs.
    always_comb begin
        row_sum = {2'b00, req_row} + {3'b000, scroll[15:8]} + (ppu_ctrl1[1] ? 11'd240 : 11'd0);
        if (row_sum >= 11'd960) begin
            row_wrap = 9'(row_sum - 11'd960);
        end else if (row_sum >= 11'd480) begin
            row_wrap = 9'(row_sum - 11'd480);
        end else begin
            row_wrap = row_sum[8:0];
        end
        col_wrap = req_col + {1'b0, scroll[7:0]} + {ppu_ctrl1[0], 8'd0};
        raw_sel  = {row_wrap >= 9'd240, col_wrap[8]};
        r_local  = (row_wrap >= 9'd240) ? 8'(row_wrap - 9'd240) : row_wrap[7:0];
    end

`ifdef MIRROR_REMAP_EN
    assign eff_sel = mirror_sel(mirror_mode, raw_sel);
    logic unused_bits;
    assign unused_bits = ^{ppu_ctrl1[7:5], ppu_ctrl1[3:2], col_wrap[2:0]};
`else
    assign eff_sel = raw_sel;
    logic unused_bits;
    assign unused_bits = ^{mirror_mode, ppu_ctrl1[7:5], ppu_ctrl1[3:2], col_wrap[2:0]};
`endif

    assign attr_shift   = {tr_reg[1], tc_reg[1], 1'b0};
    assign attr_shifted = mem_rdata >> attr_shift;

    assign req_ready = rst_n & (state == ST_IDLE) & (fifo_count < DEPTH_C) & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            mem_req    <= 1'b0;
            mem_addr   <= 16'h0000;
            sel_reg    <= 2'b00;
            tr_reg     <= 5'd0;
            tc_reg     <= 5'd0;
            fy_reg     <= 3'd0;
            fine_x_reg <= 3'd0;
            pt_hi_reg  <= 1'b0;
            idx_reg    <= 8'h00;
            pal_reg    <= 2'b00;
            lo_reg     <= 8'h00;
            hi_reg     <= 8'h00;
        end else if (flush) begin
            // An outstanding bus read is never abandoned; wait out its ack and drop the data.
            if (mem_req && !mem_ack) begin
                state <= ST_DRAIN;
            end else begin
                state   <= ST_IDLE;
                mem_req <= 1'b0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        sel_reg    <= eff_sel;
                        tr_reg     <= r_local[7:3];
                        tc_reg     <= col_wrap[7:3];
                        fy_reg     <= r_local[2:0];
                        fine_x_reg <= req_col[2:0];
                        pt_hi_reg  <= ppu_ctrl1[4];
                        mem_req    <= 1'b1;
                        mem_addr   <= nt_addr(NT_BASE, eff_sel, r_local[7:3], col_wrap[7:3]);
                        state      <= ST_NT;
                    end
                end
                ST_NT: begin
                    if (mem_ack) begin
                        idx_reg  <= mem_rdata;
                        mem_addr <= at_addr(NT_BASE, sel_reg, tr_reg, tc_reg);
                        state    <= ST_AT;
                    end
                end
                ST_AT: begin
                    if (mem_ack) begin
                        pal_reg  <= attr_shifted[1:0];
                        mem_addr <= (pt_hi_reg ? PT_HI_BASE : 16'h0000)
                                    + {4'd0, idx_reg, 4'd0} + {13'd0, fy_reg};
                        state    <= ST_PLO;
                    end
                end
                ST_PLO: begin
                    if (mem_ack) begin
                        lo_reg   <= mem_rdata;
                        mem_addr <= mem_addr + PT_PLANE_OFF;
                        state    <= ST_PHI;
                    end
                end
                ST_PHI: begin
                    if (mem_ack) begin
                        hi_reg  <= mem_rdata;
                        mem_req <= 1'b0;
                        state   <= ST_PUSH;
                    end
                end
                ST_PUSH: begin
                    state <= ST_IDLE;
                end
                ST_DRAIN: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign fifo_push       = (state == ST_PUSH) & ~flush;
    assign fifo_din.pat_lo = lo_reg;
    assign fifo_din.pat_hi = hi_reg;
    assign fifo_din.pal    = pal_reg;
    assign fifo_din.fine_x = fine_x_reg;

    bg_tile_fetcher_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (tile_ready),
        .dout  (fifo_dout),
        .valid (tile_valid),
        .count (fifo_count)
    );

    assign tile_pat_lo = fifo_dout.pat_lo;
    assign tile_pat_hi = fifo_dout.pat_hi;
    assign tile_pal    = fifo_dout.pal;
    assign tile_fine_x = fifo_dout.fine_x;

endmodule

// File: tb/tb_bg_tile_fetcher.sv
// Directed bench for bg_tile_fetcher: vector table of fetches with a scripted VRAM responder,
// plus hand sequences for reset, FIFO fill/order, flush during a delayed read and async reset.
module tb_bg_tile_fetcher;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [8:0]  req_row = '0;
    logic [8:0]  req_col = '0;
    logic [15:0] scroll = '0;
    logic [7:0]  ppu_ctrl1 = '0;
    logic [1:0]  mirror_mode = '0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_rdata = '0;
    logic        tile_valid;
    logic        tile_ready = 1'b0;
    logic [7:0]  tile_pat_lo;
    logic [7:0]  tile_pat_hi;
    logic [1:0]  tile_pal;
    logic [2:0]  tile_fine_x;
    logic [1:0]  fifo_count;

    bg_tile_fetcher dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_row(req_row), .req_col(req_col), .scroll(scroll),
        .ppu_ctrl1(ppu_ctrl1), .mirror_mode(mirror_mode),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .tile_valid(tile_valid), .tile_ready(tile_ready),
        .tile_pat_lo(tile_pat_lo), .tile_pat_hi(tile_pat_hi),
        .tile_pal(tile_pal), .tile_fine_x(tile_fine_x), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0]  row;
        logic [8:0]  col;
        logic [15:0] scroll;
        logic [7:0]  ctrl;
        logic [1:0]  mirror;
        int          wait_cyc;
        logic [7:0]  d_nt;
        logic [7:0]  d_at;
        logic [7:0]  d_lo;
        logic [7:0]  d_hi;
        logic [15:0] e_nt;
        logic [15:0] e_at;
        logic [15:0] e_plo;
        logic [1:0]  e_pal;
        logic [2:0]  e_fx;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs [NV];

    int total  = 0;
    int passed = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_fetch(input vec_t v, input int id, input bit pop_after);
        int          t0;
        int          n;
        logic [1:0]  start_cnt;
        logic [15:0] exp_addr;
        logic [7:0]  dat;
        tick();
        start_cnt   = fifo_count;
        req_row     = v.row;
        req_col     = v.col;
        scroll      = v.scroll;
        ppu_ctrl1   = v.ctrl;
        mirror_mode = v.mirror;
        req_valid   = 1'b1;
        chk($sformatf("v%0d_req_ready", id), req_ready, 1);
        t0 = cyc;
        tick();
        req_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!mem_req && n < 20) begin
                tick();
                n++;
            end
            chk($sformatf("v%0d_mem_req%0d", id, k), mem_req, 1);
            case (k)
                0: begin exp_addr = v.e_nt;        dat = v.d_nt; end
                1: begin exp_addr = v.e_at;        dat = v.d_at; end
                2: begin exp_addr = v.e_plo;       dat = v.d_lo; end
                default: begin exp_addr = v.e_plo + 16'h0008; dat = v.d_hi; end
            endcase
            chk($sformatf("v%0d_addr%0d", id, k), mem_addr, exp_addr);
            repeat (v.wait_cyc) tick();
            if (v.wait_cyc > 0) chk($sformatf("v%0d_hold%0d", id, k), {mem_req, mem_addr}, {1'b1, exp_addr});
            mem_ack   = 1'b1;
            mem_rdata = dat;
            tick();
            mem_ack   = 1'b0;
            mem_rdata = 8'h00;
        end
        n = 0;
        while (fifo_count != start_cnt + 2'd1 && n < 40) begin
            tick();
            n++;
        end
        chk($sformatf("v%0d_count", id), fifo_count, start_cnt + 2'd1);
        chk($sformatf("v%0d_latency", id), cyc - t0, 4 * (v.wait_cyc + 1) + 2);
        if (pop_after) begin
            chk($sformatf("v%0d_pat_lo", id), tile_pat_lo, v.d_lo);
            chk($sformatf("v%0d_pat_hi", id), tile_pat_hi, v.d_hi);
            chk($sformatf("v%0d_pal", id), tile_pal, v.e_pal);
            chk($sformatf("v%0d_fine_x", id), tile_fine_x, v.e_fx);
            tile_ready = 1'b1;
            tick();
            tile_ready = 1'b0;
            chk($sformatf("v%0d_popped", id), {tile_valid, fifo_count}, 3'b000);
        end
    endtask

    initial begin
        //        row     col     scroll     ctrl   mir wt  nt     at     lo     hi     e_nt      e_at      e_plo     pal   fx
        vecs[0] = '{9'd0,   9'd0,   16'h0000, 8'h00, 2'd0, 0, 8'h12, 8'h1B, 8'hA0, 8'h50, 16'h2000, 16'h23C0, 16'h0120, 2'd3, 3'd0};
        vecs[1] = '{9'd239, 9'd255, 16'h0101, 8'h03, 2'd0, 0, 8'h80, 8'h02, 8'hA1, 8'h51, 16'h2000, 16'h23C0, 16'h0800, 2'd2, 3'd7};
        vecs[2] = '{9'd8,   9'd16,  16'h0000, 8'h01, 2'd0, 0, 8'h05, 8'h1B, 8'hA2, 8'h52, 16'h2422, 16'h27C0, 16'h0050, 2'd2, 3'd0};
        vecs[3] = '{9'd100, 9'd77,  16'h3010, 8'h10, 2'd0, 2, 8'hAB, 8'h80, 8'hA3, 8'h53, 16'h224B, 16'h23E2, 16'h1AB4, 2'd2, 3'd5};
        vecs[4] = '{9'd200, 9'd250, 16'h6420, 8'h02, 2'd0, 1, 8'hFF, 8'h40, 8'hA4, 8'h54, 16'h24E3, 16'h27C8, 16'h0FF4, 2'd1, 3'd2};
`ifdef MIRROR_REMAP_EN
        vecs[5] = '{9'd0,   9'd0,   16'h0000, 8'h01, 2'd1, 0, 8'h00, 8'h00, 8'hA5, 8'h55, 16'h2000, 16'h23C0, 16'h0000, 2'd0, 3'd0};
        vecs[6] = '{9'd230, 9'd8,   16'h1400, 8'h00, 2'd1, 0, 8'h01, 8'h03, 8'hA6, 8'h56, 16'h2421, 16'h27C0, 16'h0012, 2'd3, 3'd0};
`else
        vecs[5] = '{9'd0,   9'd0,   16'h0000, 8'h01, 2'd1, 0, 8'h00, 8'h00, 8'hA5, 8'h55, 16'h2400, 16'h27C0, 16'h0000, 2'd0, 3'd0};
        vecs[6] = '{9'd230, 9'd8,   16'h1400, 8'h00, 2'd1, 0, 8'h01, 8'h03, 8'hA6, 8'h56, 16'h2821, 16'h2BC0, 16'h0012, 2'd3, 3'd0};
`endif

        // Reset state, sampled while reset is held.
        #12;
        chk("rst_outputs", {req_ready, mem_req, tile_valid, fifo_count}, 5'b0);
        chk("rst_mem_addr", mem_addr, 16'h0000);
        chk("rst_tile", {tile_pat_lo, tile_pat_hi, tile_pal, tile_fine_x}, 21'h0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("idle_req_ready", req_ready, 1);

        // Stray ack with no request outstanding.
        mem_ack   = 1'b1;
        mem_rdata = 8'hFF;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        tick();
        chk("stray_ack", {mem_req, req_ready, fifo_count}, 4'b0100);

        for (int i = 0; i < NV; i++) do_fetch(vecs[i], i, 1'b1);

        // Fill the FIFO, confirm back-pressure, then pop one and refill; order must hold.
        do_fetch(vecs[0], 10, 1'b0);
        do_fetch(vecs[3], 11, 1'b0);
        tick();
        req_valid = 1'b1;
        chk("full_req_ready", req_ready, 0);
        tick();
        tick();
        chk("full_no_fetch", {mem_req, fifo_count}, 3'b010);
        req_valid = 1'b0;
        chk("head_a", tile_pat_lo, vecs[0].d_lo);
        tile_ready = 1'b1;
        tick();
        tile_ready = 1'b0;
        chk("after_pop_count", fifo_count, 1);
        do_fetch(vecs[4], 12, 1'b0);
        chk("head_b", tile_pat_lo, vecs[3].d_lo);
        tile_ready = 1'b1;
        tick();
        chk("head_c", tile_pat_lo, vecs[4].d_lo);
        tick();
        tile_ready = 1'b0;
        chk("drained", {tile_valid, fifo_count}, 3'b000);

        // Flush during the attribute read, with its ack arriving 3 cycles into the read.
        do_fetch(vecs[1], 13, 1'b0);
        tick();
        req_row = 9'd0; req_col = 9'd0; scroll = 16'h0000; ppu_ctrl1 = 8'h00; mirror_mode = 2'd0;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("fl_nt_req", {mem_req, mem_addr}, {1'b1, 16'h2000});
        mem_ack = 1'b1; mem_rdata = 8'h12;
        tick();
        mem_ack = 1'b0; mem_rdata = 8'h00;
        chk("fl_at_req", {mem_req, mem_addr}, {1'b1, 16'h23C0});
        flush = 1'b1;
        chk("fl_req_ready", req_ready, 0);
        tick();
        flush = 1'b0;
        chk("fl_fifo_empty", {tile_valid, fifo_count}, 3'b000);
        chk("fl_hold1", {mem_req, mem_addr}, {1'b1, 16'h23C0});
        tick();
        chk("fl_hold2", mem_req, 1);
        mem_ack = 1'b1; mem_rdata = 8'hFF;
        tick();
        mem_ack = 1'b0; mem_rdata = 8'h00;
        chk("fl_req_drop", {mem_req, req_ready}, 2'b01);
        repeat (8) tick();
        chk("fl_no_push", {tile_valid, fifo_count, mem_req}, 4'b0000);

        // Asynchronous reset in the middle of a fetch.
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("ar_busy", mem_req, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_immediate", {mem_req, req_ready, mem_addr}, 18'h0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("ar_recover_ready", req_ready, 1);
        do_fetch(vecs[2], 14, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Global watchdog so a stuck design still ends with a summary line.
    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required completion");
        $display("%0d/%0d checks passed", passed, total + 1);
        $fatal(1);
    end

endmodule
